info_frame_scheduler: RTL
=========================

# info_frame_scheduler

Runtime-programmable, multi-slot HDMI InfoFrame source. Host logic writes type, version, length and payload bytes for up to NUM_SLOTS InfoFrames. The block computes each checksum sequentially and swaps the result atomically into an active bank. On each data-island packet request it hands the packet assembler the next eligible InfoFrame, chosen round-robin, as a 24-bit header plus four 56-bit subpackets.

## Interface
- NUM_SLOTS, 4: number of independent InfoFrame slots (1..8).
- SLOT_W, $clog2(NUM_SLOTS) (min 1): slot index width.
- clk_pixel  in  1  pixel clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write strobe for one staging byte.
- cfg_slot  in  SLOT_W  target slot for cfg_we / cfg_commit.
- cfg_addr  in  5  0=type[6:0], 1=version, 2=length, 3..29=PB1..PB27; 30,31 ignored.
- cfg_wdata  in  8  write data.
- cfg_commit  in  1  start checksum/swap of cfg_slot's staging bank.
- cfg_busy  out  1  checksum engine active; cfg_we/cfg_commit ignored while high.
- slot_enable  in  NUM_SLOTS  per-slot transmit enable.
- slot_valid  out  NUM_SLOTS  slot has a committed active frame.
- pkt_req  in  1  one-cycle request for next InfoFrame.
- pkt_valid  out  1  header/sub hold a served frame.
- pkt_slot  out  SLOT_W  slot index served.
- header  out  24  {3'b000,length[4:0]}, version, {1'b1,type[6:0]}.
- sub  out  224  sub[i*56+:56] = {PB(7i+6),...,PB(7i)}; PB0 = checksum.

## Operation
- Per slot: staging bank (type, version, length, PB1..PB27) and active bank (header, PB0..PB27). Both are zero after reset.
- cfg_we while !cfg_busy writes one staging byte.
  - Length writes are clamped: values >27 are stored as 27. Bits [7:5] are dropped.
  - Type bit 7 is not stored. Header bit 7 is always 1.
- Staging writes never affect the active bank or outputs.
- Checksum FSM states: IDLE, SUM, SWAP.
  - IDLE -> SUM on cfg_commit && !cfg_busy. Latch cfg_slot and clear the 8-bit accumulator.
  - SUM walks 30 indices: header byte 0, 1, 2, then PB1..PB27, one per cycle. The accumulator adds each byte modulo 256. PBk with k > length contributes 0.
  - SUM -> SWAP after index 29.
  - SWAP writes the active bank in one cycle:
    - header
    - PB0 = (~sum + 1) mod 256
    - PBk for k ≤ length copied from staging; PBk for k > length = 0
  - SWAP sets slot_valid[slot] and returns to IDLE.
- Recommitting a valid slot replaces its contents; slot_valid stays 1 throughout.
- Arbiter on pkt_req considers eligible slots: slot_valid & slot_enable.
  - Picks the first eligible slot after last_served, wrapping modulo NUM_SLOTS.
  - Registers that slot's active header/sub into the outputs, sets pkt_valid=1 and pkt_slot, and updates last_served.
  - If no slot is eligible: pkt_valid=0; header, sub and pkt_slot hold their previous values.
- Outputs are registered copies. A later SWAP never alters the values currently presented.

## Timing
- Reset (async assert): cfg_busy=0, slot_valid=0, pkt_valid=0, pkt_slot=0, header=0, sub=0, FSM=IDLE, last_served=NUM_SLOTS-1 so the first serve is slot 0. Release is synchronous to clk_pixel.
- Commit latency, with cfg_commit sampled at edge t:
  - cfg_busy=1 from t+1 through t+31.
  - SWAP occurs at edge t+31. The active bank and slot_valid are visible from t+31; cfg_busy=0 from t+31.
  - A new commit is accepted at edge t+31 at the earliest.
- pkt_req sampled at edge t: outputs and pkt_valid update at t+1. pkt_req on consecutive cycles serves consecutive eligible slots.
- pkt_req on the same edge as SWAP of the selected slot serves the old active contents. If the slot was not yet valid, it is not eligible.
- cfg_we and cfg_commit on the same edge while idle: the write lands first, and the commit includes it.
- Reset mid-SUM aborts the operation. Active banks and slot_valid clear to 0.

## Test plan
- Reset, then commit slot 0 with type=0x03, version=0x01, length=25, all PB=0 → at t+31 slot_valid=0001. pkt_req → header=0x190183, sub[7:0]=0x63, rest of sub 0, pkt_slot=0.
- Slot 1: type=0x02, version=0x02, length=13, PB1=0x10, PB4=0x88. Also write PB20=0xFF (beyond length) → header 0x0D0282. Sum = 0x82+0x02+0x0D+0x10+0x88 = 0x129, so checksum = 0xD7. Served PB20 = 0.
- Length write 31 → header length field 27. cfg_we and cfg_commit during cfg_busy → staging and FSM unchanged, no extra cycles.
- Slots 0, 1, 3 valid, slot_enable=1011, six back-to-back pkt_req → pkt_slot 0,1,3,0,1,3. With slot_enable=0000 → pkt_valid=0 and header unchanged.
- Recommit slot 0 with PB1 changed, while issuing pkt_req on the SWAP edge → that serve shows the old PB1/checksum; the next serve of slot 0 shows the new values.
- Assert reset during SUM (cycle t+10) → all outputs 0 immediately. After release, slot_valid=0 and pkt_req yields pkt_valid=0.

Source files
------------

// File: rtl/info_frame_scheduler.sv
// info_frame_scheduler: multi-slot HDMI InfoFrame store with a sequential
// checksum engine, atomic bank swap and round-robin packet serving.
module info_frame_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [4:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  input  logic [NUM_SLOTS-1:0] slot_enable,
  output logic [NUM_SLOTS-1:0] slot_valid,
  input  logic                 pkt_req,
  output logic                 pkt_valid,
  output logic [SLOT_W-1:0]    pkt_slot,
  output logic [23:0]          header,
  output logic [223:0]         sub
);

  typedef enum logic [1:0] {IDLE, SUM, SWAP} state_t;

  state_t            state, state_nx;
  logic [4:0]        idx;
  logic [7:0]        acc;
  logic [SLOT_W-1:0] cur;
  logic [SLOT_W-1:0] last_served;

  logic [6:0]   stg_type [NUM_SLOTS];
  logic [7:0]   stg_ver  [NUM_SLOTS];
  logic [4:0]   stg_len  [NUM_SLOTS];
  logic [7:0]   stg_pb   [NUM_SLOTS][1:27];
  logic [23:0]  act_hdr  [NUM_SLOTS];
  logic [223:0] act_sub  [NUM_SLOTS];

  logic                 slot_ok;
  logic                 we_ok;
  logic                 commit_ok;
  logic [4:0]           cur_len;
  logic [23:0]          cur_hdr;
  logic [7:0]           sum_byte;
  logic [223:0]         new_sub;
  logic [NUM_SLOTS-1:0] elig;
  logic [SLOT_W-1:0]    pick;
  logic                 found;

  assign cfg_busy  = (state != IDLE);
  assign slot_ok   = int'(cfg_slot) < NUM_SLOTS;
  assign we_ok     = cfg_we && !cfg_busy && slot_ok;
  assign commit_ok = cfg_commit && !cfg_busy && slot_ok;
  assign cur_len   = stg_len[cur];
  assign cur_hdr   = {3'b000, cur_len, stg_ver[cur], 1'b1, stg_type[cur]};
  assign elig      = slot_valid & slot_enable;

  always_comb begin
    sum_byte = 8'h00;
    unique case (1'b1)
      idx == 5'd0: sum_byte = cur_hdr[7:0];
      idx == 5'd1: sum_byte = cur_hdr[15:8];
      idx == 5'd2: sum_byte = cur_hdr[23:16];
      (idx > 5'd2) && ((idx - 5'd2) <= cur_len):
        sum_byte = stg_pb[cur][idx - 5'd2];
      default: sum_byte = 8'h00;
    endcase
  end

  always_comb begin
    new_sub = '0;
    new_sub[7:0] = ~acc + 8'd1;
    for (int k = 1; k < 28; k++) begin
      if (k <= int'(cur_len)) new_sub[k*8 +: 8] = stg_pb[cur][k];
    end
  end

  // Descending scan so the nearest slot after last_served wins.
  always_comb begin
    pick  = last_served;
    found = 1'b0;
    for (int i = NUM_SLOTS; i >= 1; i--) begin
      if (elig[(int'(last_served) + i) % NUM_SLOTS]) begin
        pick  = SLOT_W'((int'(last_served) + i) % NUM_SLOTS);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (commit_ok) state_nx = SUM;
      SUM:     if (idx == 5'd29) state_nx = SWAP;
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        stg_type[s] <= '0;
        stg_ver[s]  <= '0;
        stg_len[s]  <= '0;
        for (int k = 1; k < 28; k++) stg_pb[s][k] <= '0;
      end
    end else if (we_ok) begin
      unique case (1'b1)
        cfg_addr == 5'd0: stg_type[cfg_slot] <= cfg_wdata[6:0];
        cfg_addr == 5'd1: stg_ver[cfg_slot]  <= cfg_wdata;
        cfg_addr == 5'd2:
          stg_len[cfg_slot] <= (cfg_wdata > 8'd27) ? 5'd27 : cfg_wdata[4:0];
        (cfg_addr > 5'd2) && (cfg_addr < 5'd30):
          stg_pb[cfg_slot][cfg_addr - 5'd2] <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      cur        <= '0;
      slot_valid <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        act_hdr[s] <= '0;
        act_sub[s] <= '0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (commit_ok) begin
          cur <= cfg_slot;
          acc <= '0;
          idx <= '0;
        end
        SUM: begin
          acc <= acc + sum_byte;
          idx <= idx + 5'd1;
        end
        SWAP: begin
          act_hdr[cur]    <= cur_hdr;
          act_sub[cur]    <= new_sub;
          slot_valid[cur] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      pkt_valid   <= 1'b0;
      pkt_slot    <= '0;
      header      <= '0;
      sub         <= '0;
      last_served <= SLOT_W'(NUM_SLOTS - 1);
    end else if (pkt_req) begin
      pkt_valid <= found;
      if (found) begin
        pkt_slot    <= pick;
        header      <= act_hdr[pick];
        sub         <= act_sub[pick];
        last_served <= pick;
      end
    end
  end

endmodule
